// File: rtl/me_sad_search.sv
// Full-search SAD motion estimator: serial block load, raster search area, best vector out as x then y.
// Define ME_SAD_OUT_EN to add the out_sad port carrying the winning SAD.
module me_sad_search #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned BLK   = 4,
  parameter int unsigned RANGE = 2,
  parameter int unsigned AREA  = BLK + 2*RANGE,
  parameter int unsigned SAD_W = PIX_W + $clog2(BLK*BLK),
  parameter int unsigned VEC_W = $clog2(RANGE+1) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             block_valid,
  input  logic             area_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             busy,
  output logic             out_valid,
  output logic [VEC_W-1:0] out_vector
`ifdef ME_SAD_OUT_EN
  ,
  output logic [SAD_W-1:0] out_sad
`endif
);

  localparam int unsigned NPIX  = BLK*BLK;
  localparam int unsigned IDX_W = $clog2(NPIX);
  localparam int unsigned CNT_W = $clog2(AREA);
  localparam int unsigned PL    = (BLK-1)*AREA + BLK;
  localparam int unsigned OFS   = BLK - 1 + RANGE;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_OUT} state_t;

  state_t                     r_state, w_state_nxt;
  logic [NPIX-1:0][PIX_W-1:0] r_blk;
  logic [IDX_W-1:0]           r_blk_idx, w_blk_wr_idx;
  logic                       r_blk_full, r_ovl;
  logic [PL-2:0][SAD_W-1:0]   r_pipe;
  logic [PL-1:0][SAD_W-1:0]   w_stage;
  logic [NPIX-1:0][SAD_W-1:0] w_ad;
  logic [CNT_W-1:0]           r_row, r_col;
  logic [SAD_W-1:0]           r_min_sad;
  logic [VEC_W-1:0]           r_min_x, r_min_y, r_lat_x, r_lat_y;
  logic [VEC_W-1:0]           w_cand_x, w_cand_y, w_out_vec_nxt;
  logic [1:0]                 r_ocnt;
  logic                       w_load_start, w_area_take, w_last, w_qual, w_better;
  logic                       w_out_valid_nxt;
`ifdef ME_SAD_OUT_EN
  logic [SAD_W-1:0]           r_lat_sad;
`endif

  // A block pixel starts a fresh load unless a load is already in progress
  assign w_load_start = block_valid && (r_state != S_LOAD) && !(r_state == S_OUT && r_ovl);
  assign w_blk_wr_idx = w_load_start ? '0 : r_blk_idx;
  assign w_area_take  = area_valid && !block_valid &&
                        (r_state == S_SEARCH || (r_state == S_LOAD && r_blk_full));
  assign w_last       = w_area_take && (r_row == CNT_W'(AREA-1)) && (r_col == CNT_W'(AREA-1));

  for (genvar i = 0; i < NPIX; i++) begin : g_ad
    assign w_ad[i] = (in_data >= r_blk[i]) ? SAD_W'(in_data - r_blk[i])
                                           : SAD_W'(r_blk[i] - in_data);
  end

  // Chain stage k matches block offset (k/AREA, k%AREA); off-block stages are pure delay
  assign w_stage[0] = w_ad[0];
  for (genvar k = 1; k < PL; k++) begin : g_stage
    if ((k % AREA) < BLK) begin : g_tap
      assign w_stage[k] = r_pipe[k-1] + w_ad[(k / AREA) * BLK + (k % AREA)];
    end else begin : g_dly
      assign w_stage[k] = r_pipe[k-1];
    end
  end

  // Result-stage sum belongs to a real candidate only when its window does not wrap
  assign w_qual   = (r_row >= CNT_W'(BLK-1)) && (r_col >= CNT_W'(BLK-1));
  assign w_better = w_qual && (w_stage[PL-1] < r_min_sad);
  assign w_cand_x = VEC_W'(r_col) - VEC_W'(OFS);
  assign w_cand_y = VEC_W'(OFS) - VEC_W'(r_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = 1'b0;
    w_out_vec_nxt   = '0;
    case (r_state)
      S_IDLE:   if (block_valid) w_state_nxt = S_LOAD;
      S_LOAD:   if (w_area_take) w_state_nxt = S_SEARCH;
      S_SEARCH: begin
        if (block_valid) w_state_nxt = S_LOAD;
        else if (w_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (r_ocnt == 2'd1) begin
          w_out_valid_nxt = 1'b1;
          w_out_vec_nxt   = r_lat_x;
        end else if (r_ocnt == 2'd2) begin
          w_out_valid_nxt = 1'b1;
          w_out_vec_nxt   = r_lat_y;
        end else if (r_ocnt == 2'd3) begin
          w_state_nxt = (r_ovl || block_valid) ? S_LOAD : S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_vector <= '0;
      busy       <= 1'b0;
`ifdef ME_SAD_OUT_EN
      out_sad    <= '0;
`endif
    end else begin
      out_valid  <= w_out_valid_nxt;
      out_vector <= w_out_vec_nxt;
      busy       <= (w_state_nxt != S_IDLE);
`ifdef ME_SAD_OUT_EN
      out_sad    <= w_out_valid_nxt ? r_lat_sad : '0;
`endif
    end
  end

  // Output phase counter; r_ovl marks a new block load begun while results drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ocnt <= 2'd0;
      r_ovl  <= 1'b0;
    end else begin
      r_ocnt <= (r_state == S_OUT) ? r_ocnt + 2'd1 : 2'd0;
      if (r_state != S_OUT) r_ovl <= 1'b0;
      else if (block_valid) r_ovl <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk      <= '0;
      r_blk_idx  <= '0;
      r_blk_full <= 1'b0;
    end else if (block_valid) begin
      r_blk[w_blk_wr_idx] <= in_data;
      r_blk_idx  <= (w_blk_wr_idx == IDX_W'(NPIX-1)) ? '0 : w_blk_wr_idx + IDX_W'(1);
      r_blk_full <= (w_blk_wr_idx == IDX_W'(NPIX-1)) || (r_blk_full && !w_load_start);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_min_sad <= '0;
      r_min_x   <= '0;
      r_min_y   <= '0;
      r_lat_x   <= '0;
      r_lat_y   <= '0;
`ifdef ME_SAD_OUT_EN
      r_lat_sad <= '0;
`endif
    end else if (w_load_start) begin
      r_pipe    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_min_sad <= '1;
      r_min_x   <= '0;
      r_min_y   <= '0;
    end else if (w_area_take) begin
      r_pipe <= w_stage[PL-2:0];
      if (r_col == CNT_W'(AREA-1)) begin
        r_col <= '0;
        r_row <= (r_row == CNT_W'(AREA-1)) ? '0 : r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
      if (w_better) begin
        r_min_sad <= w_stage[PL-1];
        r_min_x   <= w_cand_x;
        r_min_y   <= w_cand_y;
      end
      // Final candidate is folded in by bypass so the result is ready at OUT entry
      if (w_last) begin
        r_lat_x   <= w_better ? w_cand_x : r_min_x;
        r_lat_y   <= w_better ? w_cand_y : r_min_y;
`ifdef ME_SAD_OUT_EN
        r_lat_sad <= w_better ? w_stage[PL-1] : r_min_sad;
`endif
      end
    end
  end

endmodule

// File: tb/tb_me_sad_search.sv
// Directed bench for me_sad_search: default and BLK=8/RANGE=4 instances, scoreboard of expected vectors.
`timescale 1ns/1ps
module tb_me_sad_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bv0, av0, busy0, ov0;
  logic [7:0] d0;
  logic [2:0] vec0;
  logic       bv1, av1, busy1, ov1;
  logic [7:0] d1;
  logic [3:0] vec1;
`ifdef ME_SAD_OUT_EN
  logic [11:0] sad0;
  logic [13:0] sad1;
  int          qs0[$];
  int          qs1[$];
`endif
  int         q0[$];
  int         q1[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] sblk[64];
  logic [7:0] sarea[256];

  always #5 clk = ~clk;

  me_sad_search u_dut0 (
    .clk(clk), .rst_n(rst_n), .block_valid(bv0), .area_valid(av0), .in_data(d0),
    .busy(busy0), .out_valid(ov0), .out_vector(vec0)
`ifdef ME_SAD_OUT_EN
    , .out_sad(sad0)
`endif
  );

  me_sad_search #(.BLK(8), .RANGE(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .block_valid(bv1), .area_valid(av1), .in_data(d1),
    .busy(busy1), .out_valid(ov1), .out_vector(vec1)
`ifdef ME_SAD_OUT_EN
    , .out_sad(sad1)
`endif
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pops one expected value per out_valid cycle; vector must be 0 when idle
  task automatic mon();
    int e;
    if (ov0) begin
      if (q0.size() == 0) chk("spurious_out0", 32'(ov0), 0);
      else begin e = q0.pop_front(); chk("vec0", 32'($signed(vec0)), e); end
    end else chk("vec0_idle", 32'($signed(vec0)), 0);
    if (ov1) begin
      if (q1.size() == 0) chk("spurious_out1", 32'(ov1), 0);
      else begin e = q1.pop_front(); chk("vec1", 32'($signed(vec1)), e); end
    end else chk("vec1_idle", 32'($signed(vec1)), 0);
`ifdef ME_SAD_OUT_EN
    if (ov0) begin
      if (qs0.size() != 0) begin e = qs0.pop_front(); chk("sad0", 32'(sad0), e); end
    end else chk("sad0_idle", 32'(sad0), 0);
    if (ov1) begin
      if (qs1.size() != 0) begin e = qs1.pop_front(); chk("sad1", 32'(sad1), e); end
    end else chk("sad1_idle", 32'(sad1), 0);
`endif
  endtask

  task automatic step(input bit sel, input bit b, input bit a, input logic [7:0] d);
    bv0 = 1'b0; av0 = 1'b0; d0 = 8'h00;
    bv1 = 1'b0; av1 = 1'b0; d1 = 8'h00;
    if (sel) begin bv1 = b; av1 = a; d1 = d; end
    else     begin bv0 = b; av0 = a; d0 = d; end
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic expect_res(input bit sel, input int x, input int y, input int s);
    if (sel) begin q1.push_back(x); q1.push_back(y); end
    else     begin q0.push_back(x); q0.push_back(y); end
`ifdef ME_SAD_OUT_EN
    if (sel) begin qs1.push_back(s); qs1.push_back(s); end
    else     begin qs0.push_back(s); qs0.push_back(s); end
`else
    if (s < 0) $display("note: negative sad %0d", s);
`endif
  endtask

  task automatic send_blk(input bit sel, input int first, input int n, input bit junk);
    for (int k = first; k < n; k++) begin
      if (junk && k == 6) step(sel, 1'b0, 1'b1, 8'd200);
      step(sel, 1'b1, 1'b0, sblk[k]);
    end
  endtask

  task automatic send_area(input bit sel, input int n, input bit gap);
    int cyc = 0;
    for (int k = 0; k < n; k++) begin
      if (gap && (cyc % 3 == 2)) begin
        step(sel, 1'b0, 1'b0, 8'($urandom));
        cyc++;
      end
      step(sel, 1'b0, 1'b1, sarea[k]);
      cyc++;
    end
  endtask

  task automatic fill_area(input int aw, input int bw, input int r, input int c, input bit copy);
    for (int i = 0; i < aw*aw; i++) sarea[i] = 8'h00;
    if (copy)
      for (int i = 0; i < bw; i++)
        for (int j = 0; j < bw; j++)
          sarea[(r+i)*aw + c + j] = sblk[i*bw + j];
  endtask

  // Called right after the last area pixel; stray area_valid during OUT must be ignored
  task automatic latency(input bit sel, input string tag);
    chk({tag, "_ov_e0"}, 32'(sel ? ov1 : ov0), 0);
    step(sel, 1'b0, 1'b1, 8'hA5);
    chk({tag, "_ov_e1"}, 32'(sel ? ov1 : ov0), 0);
    step(sel, 1'b0, 1'b1, 8'h5A);
    chk({tag, "_ov_e2"}, 32'(sel ? ov1 : ov0), 1);
    step(sel, 1'b0, 1'b1, 8'hFF);
    chk({tag, "_ov_e3"}, 32'(sel ? ov1 : ov0), 1);
    step(sel, 1'b0, 1'b1, 8'h33);
    chk({tag, "_ov_e4"}, 32'(sel ? ov1 : ov0), 0);
    chk({tag, "_busy_e4"}, 32'(sel ? busy1 : busy0), 0);
    chk({tag, "_drained"}, sel ? q1.size() : q0.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bv0 = 1'b0; av0 = 1'b0; d0 = 8'h00;
    bv1 = 1'b0; av1 = 1'b0; d1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov0", 32'(ov0), 0);
    chk("rst_vec0", 32'(vec0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_ov1", 32'(ov1), 0);
    chk("rst_vec1", 32'(vec1), 0);
    chk("rst_busy1", 32'(busy1), 0);
`ifdef ME_SAD_OUT_EN
    chk("rst_sad0", 32'(sad0), 0);
    chk("rst_sad1", 32'(sad1), 0);
`endif
    rst_n = 1'b1;

    // Exact copy at row 1, col 3; area pixels in IDLE are ignored
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 8'd55);
    chk("idle_busy", 32'(busy0), 0);
    for (int k = 0; k < 16; k++) sblk[k] = 8'(k + 1);
    fill_area(8, 4, 1, 3, 1'b1);
    send_blk(1'b0, 0, 16, 1'b0);
    chk("load_busy", 32'(busy0), 1);
    expect_res(1'b0, 1, 1, 0);
    send_area(1'b0, 64, 1'b0);
    latency(1'b0, "t1");

    // All-zero: tie resolves to first raster candidate; area pixel mid-load ignored
    for (int k = 0; k < 16; k++) sblk[k] = 8'h00;
    fill_area(8, 4, 0, 0, 1'b0);
    send_blk(1'b0, 0, 16, 1'b1);
    expect_res(1'b0, -2, 2, 0);
    send_area(1'b0, 64, 1'b0);
    latency(1'b0, "t2");

    // Same as first search with area_valid low every third cycle
    for (int k = 0; k < 16; k++) sblk[k] = 8'(k + 1);
    fill_area(8, 4, 1, 3, 1'b1);
    send_blk(1'b0, 0, 16, 1'b0);
    expect_res(1'b0, 1, 1, 0);
    send_area(1'b0, 64, 1'b1);
    latency(1'b0, "t3");

    // Abort after 30 area pixels (block and area both high), restart with copy at row 4, col 0
    send_blk(1'b0, 0, 16, 1'b0);
    send_area(1'b0, 30, 1'b0);
    step(1'b0, 1'b1, 1'b1, sblk[0]);
    chk("abort_busy", 32'(busy0), 1);
    send_blk(1'b0, 1, 16, 1'b0);
    fill_area(8, 4, 4, 0, 1'b1);
    expect_res(1'b0, -2, -2, 0);
    send_area(1'b0, 64, 1'b0);
    latency(1'b0, "t4");

    // BLK=8, RANGE=4: copy at row 8, col 0, then a second block loaded during OUT
    for (int k = 0; k < 64; k++) sblk[k] = 8'(k + 1);
    fill_area(16, 8, 8, 0, 1'b1);
    send_blk(1'b1, 0, 64, 1'b0);
    expect_res(1'b1, -4, -4, 0);
    send_area(1'b1, 256, 1'b0);
    for (int k = 0; k < 64; k++) sblk[k] = 8'(100 - k);
    send_blk(1'b1, 0, 64, 1'b0);
    chk("ovl_q_empty", q1.size(), 0);
    chk("ovl_busy", 32'(busy1), 1);
    fill_area(16, 8, 3, 6, 1'b1);
    expect_res(1'b1, 2, 1, 0);
    send_area(1'b1, 256, 1'b0);
    latency(1'b1, "t5");

    // Uniform block of 10 against zero area: every SAD is 160, first candidate wins
    for (int k = 0; k < 16; k++) sblk[k] = 8'd10;
    fill_area(8, 4, 0, 0, 1'b0);
    send_blk(1'b0, 0, 16, 1'b0);
    expect_res(1'b0, -2, 2, 160);
    send_area(1'b0, 64, 1'b0);
    latency(1'b0, "t6");

    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
